regfile_access_ctrl: RTL and testbench
======================================

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 32, operand and register width.
REQ-002 SHALL have port clk_i  input  1  single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port op_valid_i  input  1 and op_ready_o  output  1  operand-fetch request handshake.
REQ-005 SHALL have ports rs1_i  input  5 and rs2_i  input  5  source register indices.
REQ-006 SHALL have ports opa_o  output  DataWidth and opb_o  output  DataWidth  fetched operands.
REQ-007 SHALL have port opnd_valid_o  output  1 and opnd_ready_i  input  1  operand-result handshake.
REQ-008 SHALL have ports wb_valid_i  input  1, wb_ready_o  output  1, wb_addr_i  input  5, wb_data_i  input  DataWidth  writeback request.
REQ-009 SHALL have ports req_ra_o, req_rb_o, req_w_o  output  1  register-file strobes; the register file acts on their rising edges.
REQ-010 SHALL have ports raddr_a_o, raddr_b_o, waddr_a_o  output  5 and wdata_a_o  output  DataWidth  register-file address and data.
REQ-011 SHALL have ports rdata_a_i, rdata_b_i  input  DataWidth  register-file read data.

Function
REQ-012 SHALL implement the FSM states IDLE, RD_SETUP, RD_STROBE, RD_CAPT, OUT, WR_SETUP, WR_STROBE.
REQ-013 SHALL drive every strobe from a flop, so strobes are glitch-free and each is high for exactly one cycle per access.
REQ-014 SHALL assert op_ready_o and wb_ready_o only in IDLE.
REQ-015 SHALL accept a writeback in IDLE when wb_valid_i=1, and SHALL give it priority over a simultaneous op_valid_i (op_ready_o=0 in that cycle).
REQ-016 SHALL latch wb_addr_i/wb_data_i on acceptance, then go to WR_SETUP with waddr_a_o/wdata_a_o stable and req_w_o=0, then WR_STROBE with req_w_o=1, then IDLE.
REQ-017 SHALL consume a writeback to x0 in one cycle, stay in IDLE, and issue no req_w_o.
REQ-018 SHALL latch rs1_i/rs2_i on op acceptance, then follow the sequence RD_SETUP (addresses stable, strobes 0) -> RD_STROBE (req_ra_o=req_rb_o=1) -> RD_CAPT (sample rdata_a_i/rdata_b_i at end of cycle) -> OUT.
REQ-019 SHALL suppress the strobe for any port addressed to x0 and force that operand to 0, keeping the same cycle count.
REQ-020 SHALL assert opnd_valid_o in the 4th cycle after the op acceptance edge.
REQ-021 SHALL hold opnd_valid_o, opa_o and opb_o stable in OUT until opnd_ready_i=1, then return to IDLE.
REQ-022 SHALL hold raddr/waddr/wdata stable from the SETUP state through the cycle after the strobe falls.

Reset
REQ-023 SHALL, while rst_i=1 at a clock edge, enter IDLE and clear all strobes, opnd_valid_o, opa_o, opb_o, and all address and data outputs to 0.
REQ-024 SHALL abandon any in-flight access on reset mid-operation, with no strobe rising in the cycle after reset is sampled.
REQ-025 SHALL hold op_ready_o=wb_ready_o=0 during reset and raise them in the first cycle after rst_i falls.

Configuration
REQ-026 SHALL, with REGFILE_ACCESS_STATS_EN defined, add outputs rd_cnt_o and wr_cnt_o (16 bits each) that count issued req_ra_o/req_rb_o rising edges (each counts 1) and req_w_o rising edges, saturate at 0xFFFF, and clear on reset.
REQ-027 SHALL, without REGFILE_ACCESS_STATS_EN, omit both ports and the counters, leaving all other behaviour identical.

Verification
REQ-028 SHALL cover: wb x5=0xDEADBEEF, then op rs1=5, rs2=0 -> one req_w_o pulse, one req_ra_o pulse, no req_rb_o, opa_o=0xDEADBEEF, opb_o=0.
REQ-029 SHALL cover: op_valid_i and wb_valid_i both high in IDLE (wb x3=0x11, op rs1=3) -> write completes first, then opa_o=0x11.
REQ-030 SHALL cover: opnd_ready_i=0 for 5 cycles in OUT -> opnd_valid_o and operands stay stable, no further strobes, op_ready_o=0.
REQ-031 SHALL cover: wb to x0 with data 0xFFFFFFFF -> no req_w_o, wb_ready_o=1 the next cycle, and a later read of x0 returns 0.
REQ-032 SHALL cover: rst_i asserted during RD_STROBE -> next cycle IDLE with all outputs 0, and no opnd_valid_o for the aborted op.
REQ-033 SHALL cover: with REGFILE_ACCESS_STATS_EN, 3 reads (rs1=1, rs2=2) and 2 writes -> rd_cnt_o=6, wr_cnt_o=2.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences operand reads and writebacks onto a strobe-driven register file
// Ports: clk_i/rst_i clock and synchronous active-high reset; op_valid_i/op_ready_o with rs1_i/rs2_i
//   operand-fetch request; opnd_valid_o/opnd_ready_i with opa_o/opb_o fetched operands;
//   wb_valid_i/wb_ready_o with wb_addr_i/wb_data_i writeback request; req_ra_o/req_rb_o/req_w_o
//   register-file strobes; raddr_a_o/raddr_b_o/waddr_a_o/wdata_a_o addresses and write data;
//   rdata_a_i/rdata_b_i register-file read data.
// Define REGFILE_ACCESS_STATS_EN to add rd_cnt_o/wr_cnt_o, saturating 16-bit strobe counters.
module regfile_access_ctrl #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  output logic [DataWidth-1:0] opa_o,
  output logic [DataWidth-1:0] opb_o,
  output logic                 opnd_valid_o,
  input  logic                 opnd_ready_i,
  input  logic                 wb_valid_i,
  output logic                 wb_ready_o,
  input  logic [4:0]           wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  output logic                 req_ra_o,
  output logic                 req_rb_o,
  output logic                 req_w_o,
  output logic [4:0]           raddr_a_o,
  output logic [4:0]           raddr_b_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  input  logic [DataWidth-1:0] rdata_a_i,
  input  logic [DataWidth-1:0] rdata_b_i
`ifdef REGFILE_ACCESS_STATS_EN
  ,
  output logic [15:0]          rd_cnt_o,
  output logic [15:0]          wr_cnt_o
`endif
);
  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_STROBE, RD_CAPT, OUT, WR_SETUP, WR_STROBE} state_e;
  state_e state_q, state_d;
  logic req_ra_q, req_ra_d, req_rb_q, req_rb_d, req_w_q, req_w_d;
  logic [4:0] raddr_a_q, raddr_a_d, raddr_b_q, raddr_b_d, waddr_q, waddr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d, opa_q, opa_d, opb_q, opb_d;
  logic wb_acc, op_acc;
  always_comb begin
    wb_ready_o = state_q == IDLE && !rst_i;
    op_ready_o = wb_ready_o && !wb_valid_i;
    wb_acc = wb_valid_i && wb_ready_o;
    op_acc = op_valid_i && op_ready_o;
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = wb_acc ? (wb_addr_i != '0 ? WR_SETUP : IDLE) : (op_acc ? RD_SETUP : IDLE);
      RD_SETUP:  state_d = RD_STROBE;
      RD_STROBE: state_d = RD_CAPT;
      RD_CAPT:   state_d = OUT;
      OUT:       state_d = opnd_ready_i ? IDLE : OUT;
      WR_SETUP:  state_d = WR_STROBE;
      default:   state_d = IDLE;
    endcase
    // strobes are registered one state ahead so they are flop outputs, never decoded glitches
    req_ra_d = state_q == RD_SETUP && raddr_a_q != '0;
    req_rb_d = state_q == RD_SETUP && raddr_b_q != '0;
    req_w_d = state_q == WR_SETUP;
    raddr_a_d = op_acc ? rs1_i : raddr_a_q;
    raddr_b_d = op_acc ? rs2_i : raddr_b_q;
    waddr_d = wb_acc && wb_addr_i != '0 ? wb_addr_i : waddr_q;
    wdata_d = wb_acc && wb_addr_i != '0 ? wb_data_i : wdata_q;
    opa_d = state_q == RD_CAPT ? (raddr_a_q == '0 ? '0 : rdata_a_i) : opa_q;
    opb_d = state_q == RD_CAPT ? (raddr_b_q == '0 ? '0 : rdata_b_i) : opb_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_ra_q <= 1'b0;
      req_rb_q <= 1'b0;
      req_w_q <= 1'b0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      state_q <= state_d;
      req_ra_q <= req_ra_d;
      req_rb_q <= req_rb_d;
      req_w_q <= req_w_d;
      raddr_a_q <= raddr_a_d;
      raddr_b_q <= raddr_b_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end
  assign opnd_valid_o = state_q == OUT;
  assign req_ra_o = req_ra_q;
  assign req_rb_o = req_rb_q;
  assign req_w_o = req_w_q;
  assign raddr_a_o = raddr_a_q;
  assign raddr_b_o = raddr_b_q;
  assign waddr_a_o = waddr_q;
  assign wdata_a_o = wdata_q;
  assign opa_o = opa_q;
  assign opb_o = opb_q;
`ifdef REGFILE_ACCESS_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  logic [16:0] rd_sum;
  // both read strobes can rise on the same edge, so the read count may advance by two
  assign rd_sum = {1'b0, rd_cnt_q} + {16'd0, req_ra_d} + {16'd0, req_rb_d};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_sum[16] ? 16'hFFFF : rd_sum[15:0];
      wr_cnt_q <= wr_cnt_q + {15'd0, req_w_d && wr_cnt_q != 16'hFFFF};
    end
  end
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: table, directed and random checks of regfile_access_ctrl against a register-array model
module tb_regfile_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, op_valid, op_ready, opnd_valid, opnd_ready, wb_valid, wb_ready, req_ra, req_rb, req_w;
  logic [4:0] rs1, rs2, wb_addr, raddr_a, raddr_b, waddr_a;
  logic [31:0] opa, opb, wb_data, wdata_a;
  logic [31:0] rdata_a = '0;
  logic [31:0] rdata_b = '0;
`ifdef REGFILE_ACCESS_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;
`endif
  regfile_access_ctrl dut (
    .clk_i(clk), .rst_i(rst), .op_valid_i(op_valid), .op_ready_o(op_ready),
    .rs1_i(rs1), .rs2_i(rs2), .opa_o(opa), .opb_o(opb),
    .opnd_valid_o(opnd_valid), .opnd_ready_i(opnd_ready),
    .wb_valid_i(wb_valid), .wb_ready_o(wb_ready), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .req_ra_o(req_ra), .req_rb_o(req_rb), .req_w_o(req_w),
    .raddr_a_o(raddr_a), .raddr_b_o(raddr_b), .waddr_a_o(waddr_a), .wdata_a_o(wdata_a),
    .rdata_a_i(rdata_a), .rdata_b_i(rdata_b)
`ifdef REGFILE_ACCESS_STATS_EN
    , .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
`endif
  );
  logic [31:0] rf [32];
  logic [31:0] ref_rf [32];
  logic ra_p = 1'b0;
  logic rb_p = 1'b0;
  logic w_p = 1'b0;
  int ra_hi, rb_hi, w_hi, exp_ra, exp_rb, exp_w, checks, fails;
  always @(negedge clk) begin
    if (req_w && !w_p) rf[waddr_a] = wdata_a;
    if (req_ra && !ra_p) rdata_a = rf[raddr_a];
    if (req_rb && !rb_p) rdata_b = rf[raddr_b];
    ra_hi += int'(req_ra);
    rb_hi += int'(req_rb);
    w_hi += int'(req_w);
    ra_p = req_ra;
    rb_p = req_rb;
    w_p = req_w;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1, "watchdog");
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 0) begin
      ref_rf[a] = d;
      exp_w++;
    end
  endtask
  task automatic check_zero(input string nm);
    check({nm, "_req_ra"}, 32'(req_ra), 0);
    check({nm, "_req_rb"}, 32'(req_rb), 0);
    check({nm, "_req_w"}, 32'(req_w), 0);
    check({nm, "_raddr_a"}, 32'(raddr_a), 0);
    check({nm, "_raddr_b"}, 32'(raddr_b), 0);
    check({nm, "_waddr"}, 32'(waddr_a), 0);
    check({nm, "_wdata"}, wdata_a, 0);
    check({nm, "_opa"}, opa, 0);
    check({nm, "_opb"}, opb, 0);
    check({nm, "_opnd_valid"}, 32'(opnd_valid), 0);
    check({nm, "_op_ready"}, 32'(op_ready), 0);
    check({nm, "_wb_ready"}, 32'(wb_ready), 0);
`ifdef REGFILE_ACCESS_STATS_EN
    check({nm, "_rd_cnt"}, 32'(rd_cnt), 0);
    check({nm, "_wr_cnt"}, 32'(wr_cnt), 0);
`endif
  endtask
  task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_addr = a;
    wb_data = d;
    while (!wb_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wb_accept_timeout", 32'(n < 50), 1);
    @(negedge clk);
    wb_valid = 1'b0;
    if (a == 0) begin
      check("wb_x0_no_strobe", 32'(req_w), 0);
      check("wb_x0_ready_next", 32'(wb_ready), 1);
    end else begin
      check("wr_setup_strobe", 32'(req_w), 0);
      check("wr_setup_addr", 32'(waddr_a), 32'(a));
      check("wr_setup_data", wdata_a, d);
      check("wr_setup_busy", 32'(wb_ready), 0);
      @(negedge clk);
      check("wr_strobe", 32'(req_w), 1);
      check("wr_strobe_addr", 32'(waddr_a), 32'(a));
      check("wr_strobe_data", wdata_a, d);
      @(negedge clk);
      check("wr_after_strobe", 32'(req_w), 0);
      check("wr_after_addr", 32'(waddr_a), 32'(a));
      check("wr_after_data", wdata_a, d);
      check("wr_done_ready", 32'(wb_ready), 1);
    end
    model_write(a, d);
  endtask
  task automatic do_op(input logic [4:0] a, input logic [4:0] b, input int hold,
                       input logic [31:0] ea, input logic [31:0] eb);
    int n = 0;
    @(negedge clk);
    op_valid = 1'b1;
    rs1 = a;
    rs2 = b;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("op_accept_timeout", 32'(n < 50), 1);
    if (n >= 50) begin
      op_valid = 1'b0;
      return;
    end
    @(negedge clk);
    op_valid = 1'b0;
    check("rd_setup_valid", 32'(opnd_valid), 0);
    check("rd_setup_strobes", {30'd0, req_ra, req_rb}, 0);
    check("rd_setup_addr", {22'd0, raddr_a, raddr_b}, {22'd0, a, b});
    @(negedge clk);
    check("rd_strobe_a", 32'(req_ra), 32'(a != 0));
    check("rd_strobe_b", 32'(req_rb), 32'(b != 0));
    check("rd_strobe_addr", {22'd0, raddr_a, raddr_b}, {22'd0, a, b});
    exp_ra += int'(a != 0);
    exp_rb += int'(b != 0);
    @(negedge clk);
    check("rd_capt_valid", 32'(opnd_valid), 0);
    check("rd_capt_strobes", {30'd0, req_ra, req_rb}, 0);
    check("rd_capt_addr", {22'd0, raddr_a, raddr_b}, {22'd0, a, b});
    @(negedge clk);
    check("out_valid_latency", 32'(opnd_valid), 1);
    check("out_opa", opa, ea);
    check("out_opb", opb, eb);
    check("out_op_ready", 32'(op_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(opnd_valid), 1);
      check("hold_opa", opa, ea);
      check("hold_opb", opb, eb);
      check("hold_no_strobe", {29'd0, req_ra, req_rb, req_w}, 0);
      check("hold_op_ready", 32'(op_ready), 0);
    end
    opnd_ready = 1'b1;
    @(negedge clk);
    opnd_ready = 1'b0;
    check("out_release_valid", 32'(opnd_valid), 0);
    check("out_release_ready", 32'(wb_ready), 1);
  endtask
  typedef struct {
    logic        is_wb;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] d;
    int          hold;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;
  vec_t vt[8];
  initial begin
    logic [4:0] ra5, rb5;
    rst = 1'b1;
    op_valid = 1'b0;
    opnd_ready = 1'b0;
    wb_valid = 1'b0;
    rs1 = '0;
    rs2 = '0;
    wb_addr = '0;
    wb_data = '0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'h1000_0000 + i;
      ref_rf[i] = rf[i];
    end
    rf[0] = 32'hBAD0_BAD0;
    ref_rf[0] = '0;
    vt[0] = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 0, 32'h0,        32'h0};
    vt[1] = '{1'b0, 5'd5,  5'd0,  32'h0,        0, 32'hDEADBEEF, 32'h0};
    vt[2] = '{1'b1, 5'd0,  5'd0,  32'hFFFFFFFF, 0, 32'h0,        32'h0};
    vt[3] = '{1'b0, 5'd0,  5'd5,  32'h0,        1, 32'h0,        32'hDEADBEEF};
    vt[4] = '{1'b1, 5'd31, 5'd0,  32'hA5A55A5A, 0, 32'h0,        32'h0};
    vt[5] = '{1'b0, 5'd31, 5'd5,  32'h0,        5, 32'hA5A55A5A, 32'hDEADBEEF};
    vt[6] = '{1'b1, 5'd5,  5'd0,  32'h00000001, 0, 32'h0,        32'h0};
    vt[7] = '{1'b0, 5'd5,  5'd31, 32'h0,        2, 32'h00000001, 32'hA5A55A5A};
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    #1;
    check("reset_release_op_ready", 32'(op_ready), 1);
    check("reset_release_wb_ready", 32'(wb_ready), 1);
    for (int i = 0; i < 8; i++)
      if (vt[i].is_wb) do_wb(vt[i].a, vt[i].d);
      else do_op(vt[i].a, vt[i].b, vt[i].hold, vt[i].ea, vt[i].eb);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_addr = 5'd3;
    wb_data = 32'h11;
    op_valid = 1'b1;
    rs1 = 5'd3;
    rs2 = 5'd0;
    #1;
    check("prio_op_ready", 32'(op_ready), 0);
    check("prio_wb_ready", 32'(wb_ready), 1);
    @(negedge clk);
    wb_valid = 1'b0;
    check("prio_wr_setup", 32'(req_w), 0);
    check("prio_busy_op_ready", 32'(op_ready), 0);
    @(negedge clk);
    check("prio_wr_strobe", 32'(req_w), 1);
    check("prio_no_read", 32'(req_ra), 0);
    model_write(5'd3, 32'h11);
    do_op(5'd3, 5'd0, 0, 32'h11, 32'h0);
    @(negedge clk);
    op_valid = 1'b1;
    rs1 = 5'd7;
    rs2 = 5'd9;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    check("abort_in_strobe", {30'd0, req_ra, req_rb}, 32'd3);
    exp_ra++;
    exp_rb++;
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    #1;
    check("abort_release_ready", 32'(op_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(opnd_valid), 0);
      check("abort_no_strobe", {29'd0, req_ra, req_rb, req_w}, 0);
    end
    for (int i = 0; i < 60; i++) begin
      ra5 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rb5 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 2) == 0) do_wb(ra5, $urandom);
      else do_op(ra5, rb5, int'($urandom_range(0, 3)), ref_rf[ra5], ref_rf[rb5]);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("stats_reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) do_op(5'd1, 5'd2, 0, ref_rf[1], ref_rf[2]);
    do_wb(5'd1, 32'h1234_5678);
    do_wb(5'd2, 32'h8765_4321);
    do_op(5'd2, 5'd1, 0, 32'h8765_4321, 32'h1234_5678);
`ifdef REGFILE_ACCESS_STATS_EN
    check("stats_rd_cnt", 32'(rd_cnt), 32'd8);
    check("stats_wr_cnt", 32'(wr_cnt), 32'd2);
`endif
    @(negedge clk);
    check("count_req_ra", ra_hi, exp_ra);
    check("count_req_rb", rb_hi, exp_rb);
    check("count_req_w", w_hi, exp_w);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
